// File: rtl/fsm_debounce_multi.sv
// -----------------------------------------------------------------------------
// fsm_debounce_multi
//
// Multi-channel switch debouncer. Each channel runs an independent four-state
// FSM (ZERO, WAIT1, ONE, WAIT0) with its own stability counter. A channel
// only changes its debounced level after the raw input has held the new value
// for STABLE_CYC qualifying en strobes. Any bounce back to the old level
// aborts the wait without producing a tick.
//
// Rise/fall ticks are single-cycle pulses with one of two timings:
//   TICK_MOORE = 0 : combinational (Mealy). The tick is high in the cycle
//                    before the state changes.
//   TICK_MOORE = 1 : registered (Moore). The tick is high in the first cycle
//                    of the new state, aligned with the db_level edge.
//
// Parameters
//   CH          number of independent channels (>= 1)
//   STABLE_CYC  en strobes the input must hold stable (>= 1)
//   TICK_MOORE  tick timing select (0: Mealy, 1: Moore)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   en         sample strobe; stability counters advance only when en = 1
//   sw         raw switch levels, already synchronised to clk
//   db_level   debounced level per channel
//   rise_tick  one-cycle pulse on a debounced 0->1 transition
//   fall_tick  one-cycle pulse on a debounced 1->0 transition
// -----------------------------------------------------------------------------
module fsm_debounce_multi #(
  parameter int CH         = 4,
  parameter int STABLE_CYC = 16,
  parameter int TICK_MOORE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] rise_tick,
  output logic [CH-1:0] fall_tick
);

  // The counter is at least one bit wide, so STABLE_CYC = 1 still has a
  // legal counter. It is loaded with zero, and the first en strobe completes
  // the wait.
  localparam int             CW       = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,  // debounced 0, input agrees
    WAIT1 = 2'd1,  // debounced 0, input is 1, counting stable strobes
    ONE   = 2'd2,  // debounced 1, input agrees
    WAIT0 = 2'd3   // debounced 1, input is 0, counting stable strobes
  } state_t;

  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [CW-1:0] cnt_q   [CH];
  logic [CW-1:0] cnt_d   [CH];

  // The raw rise/fall conditions. They drive the ticks directly in Mealy
  // mode and feed the tick registers in Moore mode.
  logic [CH-1:0] rise_cond;
  logic [CH-1:0] fall_cond;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the clock edge, no matter how the
  // processes are ordered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= ZERO;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first ("hold"). Without
  // it, any path that does not assign a signal would infer a latch.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];

      unique case (state_q[c])
        ZERO: begin
          // en is ignored on the entry cycle. The wait always starts with a
          // full count.
          if (sw[c]) begin
            state_d[c] = WAIT1;
            cnt_d[c]   = CNT_LOAD;
          end
        end

        WAIT1: begin
          if (!sw[c]) begin
            state_d[c] = ZERO;                 // bounce rejected
          end else if (en) begin
            if (cnt_q[c] == '0) state_d[c] = ONE;
            else                cnt_d[c]   = cnt_q[c] - CNT_ONE;
          end
        end

        ONE: begin
          if (!sw[c]) begin
            state_d[c] = WAIT0;
            cnt_d[c]   = CNT_LOAD;
          end
        end

        WAIT0: begin
          if (sw[c]) begin
            state_d[c] = ONE;                  // bounce rejected
          end else if (en) begin
            if (cnt_q[c] == '0) state_d[c] = ZERO;
            else                cnt_d[c]   = cnt_q[c] - CNT_ONE;
          end
        end

        default: begin
          state_d[c] = ZERO;
          cnt_d[c]   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // db_level depends only on the state. A rise can only come from WAIT1 and a
  // fall only from WAIT0, so one channel can never raise both in one cycle.
  always_comb begin
    db_level  = '0;
    rise_cond = '0;
    fall_cond = '0;
    for (int c = 0; c < CH; c++) begin
      db_level[c]  = (state_q[c] == ONE) || (state_q[c] == WAIT0);
      rise_cond[c] = (state_q[c] == WAIT1) &&  sw[c] && en && (cnt_q[c] == '0);
      fall_cond[c] = (state_q[c] == WAIT0) && !sw[c] && en && (cnt_q[c] == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Tick timing
  // ---------------------------------------------------------------------------
  generate
    if (TICK_MOORE != 0) begin : g_moore_ticks
      logic [CH-1:0] rise_q;
      logic [CH-1:0] fall_q;

      // A condition lasts only one cycle, because the state leaves WAITx on
      // the same edge. So the registered tick is high for exactly the first
      // cycle of ONE/ZERO.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rise_q <= '0;
          fall_q <= '0;
        end else begin
          rise_q <= rise_cond;
          fall_q <= fall_cond;
        end
      end

      assign rise_tick = rise_q;
      assign fall_tick = fall_q;
    end else begin : g_mealy_ticks
      assign rise_tick = rise_cond;
      assign fall_tick = fall_cond;
    end
  endgenerate

endmodule

// File: tb/tb_fsm_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_fsm_debounce_multi
//
// Four instances of the debouncer share the same stimulus:
//   inst 0 : STABLE_CYC=3, Mealy ticks
//   inst 1 : STABLE_CYC=3, Moore ticks
//   inst 2 : STABLE_CYC=1, Mealy ticks
//   inst 3 : STABLE_CYC=1, Moore ticks
//
// The reference model tracks, per channel, only the debounced level, whether
// a change is pending, and how many en strobes the new value has survived.
// A change completes on the STABLE_CYC-th strobe after the cycle in which the
// difference was first seen.
// -----------------------------------------------------------------------------
module tb_fsm_debounce_multi;

  localparam int CH = 4;
  localparam int NI = 4;

  logic          clk;
  logic          reset;
  logic          en;
  logic [CH-1:0] sw;

  logic [CH-1:0] dut_db   [NI];
  logic [CH-1:0] dut_rise [NI];
  logic [CH-1:0] dut_fall [NI];

  int stable_of [NI] = '{3, 3, 1, 1};
  bit moore_of  [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};

  int checks = 0;
  int errors = 0;

  fsm_debounce_multi #(.CH(CH), .STABLE_CYC(3), .TICK_MOORE(0)) u_mealy3 (
    .clk(clk), .reset(reset), .en(en), .sw(sw),
    .db_level(dut_db[0]), .rise_tick(dut_rise[0]), .fall_tick(dut_fall[0]));
  fsm_debounce_multi #(.CH(CH), .STABLE_CYC(3), .TICK_MOORE(1)) u_moore3 (
    .clk(clk), .reset(reset), .en(en), .sw(sw),
    .db_level(dut_db[1]), .rise_tick(dut_rise[1]), .fall_tick(dut_fall[1]));
  fsm_debounce_multi #(.CH(CH), .STABLE_CYC(1), .TICK_MOORE(0)) u_mealy1 (
    .clk(clk), .reset(reset), .en(en), .sw(sw),
    .db_level(dut_db[2]), .rise_tick(dut_rise[2]), .fall_tick(dut_fall[2]));
  fsm_debounce_multi #(.CH(CH), .STABLE_CYC(1), .TICK_MOORE(1)) u_moore1 (
    .clk(clk), .reset(reset), .en(en), .sw(sw),
    .db_level(dut_db[3]), .rise_tick(dut_rise[3]), .fall_tick(dut_fall[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit lvl     [NI][CH];  // debounced level
  bit pending [NI][CH];  // a different input value has been seen
  int strobes [NI][CH];  // en strobes survived while pending
  bit trise_q [NI][CH];  // last cycle's rise event (Moore timing)
  bit tfall_q [NI][CH];  // last cycle's fall event (Moore timing)

  // True when the change completes on this cycle's edge.
  function automatic bit completes(int i, int c);
    return pending[i][c] && (sw[c] != lvl[i][c]) && en &&
           (strobes[i][c] == stable_of[i] - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < CH; c++) begin
          lvl[i][c]     <= 1'b0;
          pending[i][c] <= 1'b0;
          strobes[i][c] <= 0;
          trise_q[i][c] <= 1'b0;
          tfall_q[i][c] <= 1'b0;
        end
    end else begin
      for (int i = 0; i < NI; i++)
        for (int c = 0; c < CH; c++) begin
          trise_q[i][c] <= completes(i, c) && !lvl[i][c];
          tfall_q[i][c] <= completes(i, c) &&  lvl[i][c];
          if (!pending[i][c]) begin
            if (sw[c] != lvl[i][c]) begin
              pending[i][c] <= 1'b1;
              strobes[i][c] <= 0;
            end
          end else if (sw[c] == lvl[i][c]) begin
            pending[i][c] <= 1'b0;
          end else if (en) begin
            if (completes(i, c)) begin
              lvl[i][c]     <= ~lvl[i][c];
              pending[i][c] <= 1'b0;
            end else begin
              strobes[i][c] <= strobes[i][c] + 1;
            end
          end
        end
    end
  end

  // Compare every output of every instance on each falling edge.
  logic [CH-1:0] exp_db, exp_rise, exp_fall;
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < CH; c++) begin
        exp_db[c] = lvl[i][c];
        if (moore_of[i]) begin
          exp_rise[c] = trise_q[i][c];
          exp_fall[c] = tfall_q[i][c];
        end else begin
          exp_rise[c] = completes(i, c) && !lvl[i][c];
          exp_fall[c] = completes(i, c) &&  lvl[i][c];
        end
      end
      check($sformatf("db_level inst%0d", i),  32'(dut_db[i]),   32'(exp_db));
      check($sformatf("rise_tick inst%0d", i), 32'(dut_rise[i]), 32'(exp_rise));
      check($sformatf("fall_tick inst%0d", i), 32'(dut_fall[i]), 32'(exp_fall));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  int rise_count;

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    sw    = '0;
    #3;
    check("reset db mealy3", 32'(dut_db[0]), 32'h0);
    check("reset rise moore3", 32'(dut_rise[1]), 32'h0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    step(2);

    // 1: clean rise on channel 0; the next edge is edge k
    sw = 4'b0001;
    step(1);  // after k
    check("t1 mealy1 rise k", 32'(dut_rise[2]), 32'h1);
    step(1);  // after k+1
    check("t1 mealy1 db k+1", 32'(dut_db[2]), 32'h1);
    check("t1 moore1 rise k+1", 32'(dut_rise[3]), 32'h1);
    check("t1 mealy1 rise k+1", 32'(dut_rise[2]), 32'h0);
    step(1);  // after k+2
    check("t1 mealy3 rise k+2", 32'(dut_rise[0]), 32'h1);
    check("t1 mealy3 db k+2", 32'(dut_db[0]), 32'h0);
    step(1);  // after k+3
    check("t1 mealy3 db k+3", 32'(dut_db[0]), 32'h1);
    check("t1 mealy3 rise k+3", 32'(dut_rise[0]), 32'h0);
    check("t1 moore3 rise k+3", 32'(dut_rise[1]), 32'h1);
    check("t1 moore3 db k+3", 32'(dut_db[1]), 32'h1);
    step(1);
    check("t1 moore3 rise k+4", 32'(dut_rise[1]), 32'h0);

    // 2: two-cycle bounce on channel 1
    sw = 4'b0011;
    step(2);
    sw = 4'b0001;
    step(5);
    check("t2 mealy3 db", 32'(dut_db[0]), 32'h1);
    check("t2 moore3 db", 32'(dut_db[1]), 32'h1);

    // 3: en every 4th cycle, sw[2] held high
    en = 1'b0;
    sw = 4'b0101;
    step(1);  // channel 2 enters WAIT1
    rise_count = 0;
    for (int i = 0; i < 16; i++) begin
      en = (i % 4 == 3);
      #1;
      if (dut_rise[0][2]) rise_count++;
      @(posedge clk);
      #1;
      if (i == 8) check("t3 db after 2 strobes", 32'(dut_db[0][2]), 32'h0);
    end
    check("t3 db after 3 strobes", 32'(dut_db[0][2]), 32'h1);
    check("t3 rise count", 32'(rise_count), 32'd1);
    en = 1'b1;

    // 4: all channels fall together
    sw = 4'hF;
    step(6);
    sw = 4'h0;
    step(3);  // after k+2
    check("t4 mealy3 fall", 32'(dut_fall[0]), 32'hF);
    check("t4 mealy3 db before", 32'(dut_db[0]), 32'hF);
    step(1);  // after k+3
    check("t4 mealy3 db after", 32'(dut_db[0]), 32'h0);
    check("t4 mealy3 fall after", 32'(dut_fall[0]), 32'h0);
    check("t4 moore3 fall", 32'(dut_fall[1]), 32'hF);
    check("t4 moore3 db", 32'(dut_db[1]), 32'h0);
    step(5);

    // 5: reset while channel 3 is in WAIT1 with cnt=1
    sw = 4'h7;
    step(6);
    sw = 4'hF;
    step(2);
    #2;
    reset = 1'b1;
    #1;
    check("t5 mealy3 db in reset", 32'(dut_db[0]), 32'h0);
    check("t5 moore3 db in reset", 32'(dut_db[1]), 32'h0);
    check("t5 moore3 rise in reset", 32'(dut_rise[1]), 32'h0);
    @(posedge clk); #3;
    reset = 1'b0;
    step(3);  // after k'+2
    check("t5 mealy3 rise", 32'(dut_rise[0]), 32'hF);
    check("t5 mealy3 db before", 32'(dut_db[0]), 32'h0);
    step(1);
    check("t5 mealy3 db after", 32'(dut_db[0]), 32'hF);
    check("t5 moore3 rise", 32'(dut_rise[1]), 32'hF);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
